nios_irq_aggregator: RTL and testbench

Collects up to 16 peripheral interrupt lines and presents one prioritised request to the Nios II CPU. Typical sources are interval-timer irq and PIO irqs. Each source is individually maskable and selectable as level or rising-edge captured. The block exposes pending, mask, mode, vector and raw registers on a 16-bit Avalon-MM slave.

---
 rtl/nios_irq_aggregator.sv | 180 ++++++++++++++++++
 tb/tb_nios_irq_aggregator.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_irq_aggregator.sv
`timescale 1ns / 1ps
// nios_irq_aggregator
//
// Collects up to 16 peripheral interrupt lines and presents one prioritised
// request to the Nios II CPU over a 16-bit Avalon-MM slave. Each source can be
// masked, and can be captured either as a level or as a rising edge.
//
// Build option:
//   IRQ_AGG_SYNC_EN - when defined, irq_in passes through a 2-flop synchroniser
//                     before edge detection, level tracking and the RAW view.
//                     When undefined, irq_in must already be synchronous to clk.
//
// Register map (word addresses, bits above NUM_SRC-1 read 0 / ignore writes):
//   0 PENDING  R, write-1-to-clear (edge-mode bits only)
//   1 MASK     RW, 1 = source enabled
//   2 MODE     RW, 1 = rising edge, 0 = level
//   3 VECTOR   R, bit15 = any active, bits[3:0] = winning index
//   4 RAW      R, current (optionally synchronised) source levels
//   5 SOFT_SET W, sets edge-mode pending bits; reads 0
//   6,7        read 0, writes ignored
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    Avalon word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   registered read data, latency 1, not gated by chipselect
//   irq_in     source interrupt lines, active-high
//   irq        aggregated request to the CPU
//   irq_index  lowest-numbered active source, 0 when none

module nios_irq_aggregator #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq,
  output logic [PRIO_W-1:0]  irq_index
);

  localparam logic [2:0] AddrPending = 3'd0;
  localparam logic [2:0] AddrMask    = 3'd1;
  localparam logic [2:0] AddrMode    = 3'd2;
  localparam logic [2:0] AddrVector  = 3'd3;
  localparam logic [2:0] AddrRaw     = 3'd4;
  localparam logic [2:0] AddrSoftSet = 3'd5;

  logic [NUM_SRC-1:0] src;
  logic [NUM_SRC-1:0] src_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] wdata;
  logic [NUM_SRC-1:0] set_edge, clr_edge, edge_next;
  logic [15:0]        readdata_d;
  logic [PRIO_W-1:0]  index_c;
  logic               wr_en;
  logic               we_pending, we_mask, we_mode, we_soft;
  logic               unused_wdata;

  // ---------------------------------------------------------------------------
  // Source conditioning
  // ---------------------------------------------------------------------------
`ifdef IRQ_AGG_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign src = sync2_q;
`else
  assign src = irq_in;
`endif

  // src_prev_q resets to 0, so a source held high through reset release is seen
  // as a rising edge only if its bit is already in edge mode (it is not: MODE
  // resets to level).
  assign rise = src & ~src_prev_q;

  // ---------------------------------------------------------------------------
  // Avalon write decode
  // ---------------------------------------------------------------------------
  assign wr_en        = chipselect & ~write_n;
  assign we_pending   = wr_en & (address == AddrPending);
  assign we_mask      = wr_en & (address == AddrMask);
  assign we_mode      = wr_en & (address == AddrMode);
  assign we_soft      = wr_en & (address == AddrSoftSet);
  assign wdata        = writedata[NUM_SRC-1:0];
  // Upper writedata bits are unused when NUM_SRC < 16.
  assign unused_wdata = ^writedata;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    set_edge  = rise | (we_soft ? wdata : '0);
    clr_edge  = we_pending ? wdata : '0;
    // Set has priority over a simultaneous write-1-to-clear.
    edge_next = set_edge | (pending_q & ~clr_edge);
    // The mode in force before this edge decides how each bit updates: a bit
    // switched to edge mode keeps the level it had until cleared, a bit
    // switched to level mode tracks the source from the following edge.
    pending_d = (mode_q & edge_next) | (~mode_q & src);
    mask_d    = we_mask ? wdata : mask_q;
    mode_d    = we_mode ? wdata : mode_q;
  end

  // ---------------------------------------------------------------------------
  // Priority encode: lowest index wins
  // ---------------------------------------------------------------------------
  assign active = pending_q & mask_q;

  always_comb begin
    index_c = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active[i]) begin
        index_c = PRIO_W'(i);
      end
    end
  end

  assign irq       = |active;
  assign irq_index = index_c;

  // ---------------------------------------------------------------------------
  // Read mux (registered, no chipselect gating)
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata_d = '0;
    case (address)
      AddrPending: readdata_d = 16'(pending_q);
      AddrMask:    readdata_d = 16'(mask_q);
      AddrMode:    readdata_d = 16'(mode_q);
      AddrVector: begin
        readdata_d[15]          = irq;
        readdata_d[PRIO_W-1:0]  = index_c;
      end
      AddrRaw:     readdata_d = 16'(src);
      default:     readdata_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      mode_q     <= '0;
      readdata   <= '0;
    end else begin
      src_prev_q <= src;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      readdata   <= readdata_d;
    end
  end

endmodule

// File: tb/tb_nios_irq_aggregator.sv
`timescale 1ns / 1ps
// Self-checking bench for nios_irq_aggregator. Register reads are queued with
// their expected value when issued and compared by a monitor one cycle later;
// irq / irq_index are compared inline by each scenario task.

module tb_nios_irq_aggregator;

  localparam int NumSrc = 8;
`ifdef IRQ_AGG_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic              clk;
  logic              reset_n;
  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic [NumSrc-1:0] irq_in;
  logic              irq;
  logic [3:0]        irq_index;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] exp;
    logic [2:0]  addr;
    int          due;
  } rd_t;

  rd_t sb[$];
  rd_t mon_e;

  nios_irq_aggregator #(
    .NUM_SRC (NumSrc),
    .PRIO_W  (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq),
    .irq_index  (irq_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-data scoreboard: an entry is due one clock after its address is driven.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      if (sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        checks++;
        if (readdata !== mon_e.exp) begin
          fails++;
          $display("FAIL read_addr%0d: got 0x%04h expected 0x%04h", mon_e.addr, readdata,
                   mon_e.exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e);
    rd_t t;
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    t.exp      = e;
    t.addr     = a;
    t.due      = cyc + 1;
    sb.push_back(t);
  endtask

  task automatic test_reset;
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    irq_in     = '0;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (readdata !== 16'h0000) begin
      fails++;
      $display("FAIL reset_readdata: got 0x%04h expected 0x0000", readdata);
    end
    checks++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_irq: got %0b expected 0", irq);
    end
    checks++;
    if (irq_index !== 4'd0) begin
      fails++;
      $display("FAIL reset_index: got %0d expected 0", irq_index);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000);
  endtask

  task automatic test_edge;
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL edge_idle: irq=%0b expected 0", irq);
    end
    irq_in[0] = 1'b1;
    for (int c = 0; c <= SyncLat; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) irq_in[0] = 1'b0;
      checks++;
      if (irq !== 1'(c == SyncLat)) begin
        fails++;
        $display("FAIL edge_latency c=%0d: irq=%0b expected %0b", c, irq, c == SyncLat);
      end
    end
    checks++;
    if (irq_index !== 4'd0) begin
      fails++;
      $display("FAIL edge_index: got %0d expected 0", irq_index);
    end
    rd(3'd0, 16'h0001);
    rd(3'd3, 16'h8000);
    rd(3'd4, 16'h0000);
    wr(3'd0, 16'h0001);
    checks++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL edge_w1c: irq=%0b expected 0", irq);
    end
    rd(3'd0, 16'h0000);
  endtask

  task automatic test_level;
    logic exp_b;
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0004);
    for (int c = 1; c <= 5 + SyncLat + 2; c++) begin
      @(negedge clk);
      irq_in[2] = 1'(c <= 5);
      if (c == 3) begin
        // W1C while the level source is high must have no effect.
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 16'h0004;
      end else begin
        chipselect = 1'b0;
        write_n    = 1'b1;
      end
      @(posedge clk);
      #1;
      exp_b = 1'((c - SyncLat >= 1) && (c - SyncLat <= 5));
      checks++;
      if (irq !== exp_b) begin
        fails++;
        $display("FAIL level_irq c=%0d: irq=%0b expected %0b", c, irq, exp_b);
      end
      checks++;
      if (irq_index !== (exp_b ? 4'd2 : 4'd0)) begin
        fails++;
        $display("FAIL level_index c=%0d: got %0d expected %0d", c, irq_index,
                 exp_b ? 2 : 0);
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_soft_set;
    wr(3'd1, 16'hFFFF);
    rd(3'd1, 16'h00FF);
    wr(3'd2, 16'h00FF);
    rd(3'd2, 16'h00FF);
    wr(3'd5, 16'h0028);
    checks++;
    if (irq !== 1'b1 || irq_index !== 4'd3) begin
      fails++;
      $display("FAIL soft_set: irq=%0b index=%0d expected irq=1 index=3", irq, irq_index);
    end
    rd(3'd0, 16'h0028);
    rd(3'd5, 16'h0000);
    rd(3'd3, 16'h8003);
    wr(3'd1, 16'h0000);
    checks++;
    if (irq !== 1'b0 || irq_index !== 4'd0) begin
      fails++;
      $display("FAIL mask_off: irq=%0b index=%0d expected irq=0 index=0", irq, irq_index);
    end
    rd(3'd3, 16'h0000);
    wr(3'd1, 16'h00FF);
    checks++;
    if (irq !== 1'b1 || irq_index !== 4'd3) begin
      fails++;
      $display("FAIL mask_on: irq=%0b index=%0d expected irq=1 index=3", irq, irq_index);
    end
    wr(3'd0, 16'h0008);
    checks++;
    if (irq_index !== 4'd5) begin
      fails++;
      $display("FAIL clear_bit3: index=%0d expected 5", irq_index);
    end
    wr(3'd0, 16'h0020);
    checks++;
    if (irq !== 1'b0 || irq_index !== 4'd0) begin
      fails++;
      $display("FAIL clear_bit5: irq=%0b index=%0d expected irq=0 index=0", irq, irq_index);
    end
    rd(3'd0, 16'h0000);
    wr(3'd5, 16'hFF00);
    rd(3'd0, 16'h0000);
    wr(3'd6, 16'hFFFF);
    rd(3'd6, 16'h0000);
    rd(3'd7, 16'h0000);
  endtask

  task automatic test_set_wins;
    wr(3'd5, 16'h0002);
    checks++;
    if (irq_index !== 4'd1) begin
      fails++;
      $display("FAIL setwins_pre: index=%0d expected 1", irq_index);
    end
    @(negedge clk);
    irq_in[1] = 1'b1;
    repeat (SyncLat) @(negedge clk);
    // W1C lands on the same edge that sees the rising edge.
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 3'd0;
    writedata  = 16'h0002;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    checks++;
    if (irq !== 1'b1 || irq_index !== 4'd1) begin
      fails++;
      $display("FAIL set_wins: irq=%0b index=%0d expected irq=1 index=1", irq, irq_index);
    end
    rd(3'd0, 16'h0002);
    wr(3'd0, 16'h0002);
    checks++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL setwins_clear: irq=%0b expected 0", irq);
    end
    rd(3'd0, 16'h0000);
    irq_in[1] = 1'b0;
  endtask

  task automatic test_mid_reset;
    wr(3'd5, 16'h0001);
    checks++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre: irq=%0b expected 1", irq);
    end
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0 || irq_index !== 4'd0 || readdata !== 16'h0000) begin
      fails++;
      $display("FAIL midrst: irq=%0b index=%0d readdata=0x%04h expected 0/0/0x0000", irq,
               irq_index, readdata);
    end
    irq_in[0] = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (SyncLat) @(negedge clk);
    rd(3'd1, 16'h0000);
    rd(3'd2, 16'h0000);
    rd(3'd4, 16'h0001);
    rd(3'd0, 16'h0001);
    wr(3'd1, 16'h0001);
    checks++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL midrst_level: irq=%0b expected 1", irq);
    end
    // Level -> edge keeps the pending bit; a held-high source gives no new edge.
    wr(3'd2, 16'h0001);
    rd(3'd0, 16'h0001);
    wr(3'd0, 16'h0001);
    rd(3'd0, 16'h0000);
    checks++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL midrst_noedge: irq=%0b expected 0", irq);
    end
    irq_in[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_soft_set();
    test_set_wins();
    test_mid_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
